reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, default 32, shall set the register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, shall set the register index width; register count NUM_REGS = 2**ADDR_W (32).
REQ-003 One clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all writes.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 reg_write  input  1  write enable, sampled on rising clk.
REQ-007 read_reg1  input  ADDR_W  read port 1 register index.
REQ-008 read_reg2  input  ADDR_W  read port 2 register index.
REQ-009 write_reg  input  ADDR_W  write port register index.
REQ-010 write_data  input  DATA_W  write port data.
REQ-011 read_data1  output  DATA_W  contents of register read_reg1.
REQ-012 read_data2  output  DATA_W  contents of register read_reg2.

Function
REQ-013 The block shall hold NUM_REGS registers of DATA_W bits, indices 0..NUM_REGS-1.
REQ-014 On each rising clk with rst_n high and reg_write=1, register write_reg shall take write_data; no other register shall change.
REQ-015 With reg_write=0, no register shall change on any clk edge.
REQ-016 Register 0 shall be hard-wired zero: writes to index 0 shall be discarded, and reads of index 0 shall return 0.
REQ-017 Reads shall be combinational (zero-cycle latency): read_dataN shall follow read_regN and register contents without a clock edge.
REQ-018 Without bypass (REQ-023), a read of the register being written shall return the old value until the write edge, then the new value in the same cycle.
REQ-019 Both read ports shall be independent; both may address the same register, including the one being written.
REQ-020 X/Z on write_reg while reg_write=1 shall not corrupt registers other than the addressed one in synthesis; simulation behaviour is unspecified.

Reset
REQ-021 While rst_n=0, all registers shall clear to 0 immediately, independent of clk; read outputs shall therefore read 0.
REQ-022 A write whose clk edge coincides with rst_n low shall be discarded; the first write after reset release shall take effect on the first rising clk with rst_n high.

Configuration
REQ-023 Macro REG_BANK_BYPASS_EN defined: when reg_write=1, write_reg!=0 and read_regN==write_reg, read_dataN shall return write_data combinationally (write-to-read forwarding, both ports); rst_n=0 overrides bypass with 0.
REQ-024 Macro REG_BANK_BYPASS_EN undefined: no forwarding; read ports shall return stored contents only (REQ-018).

Structure
REQ-025 Package reg_bank_pkg shall hold DATA_W/ADDR_W defaults, NUM_REGS, the zero-register index constant and the word typedef.
REQ-026 One sub-module reg_bank_rdport (index decode, zero-register masking, optional bypass mux) shall be instantiated once per read port.

Verification
REQ-027 Reset: rst_n=0 mid-run after writes -> all reads 0 immediately; after release, read_reg1=5 -> 0.
REQ-028 Write/read: reg_write=1, write_reg=5'h0D, write_data=32'h1234_5678, edge -> read_reg1=5'h0D returns 32'h1234_5678; read_reg2=5'h04 unaffected (0).
REQ-029 Zero register: reg_write=1, write_reg=0, write_data=32'hFFFF_FFFF, edge -> read_reg1=0 returns 0.
REQ-030 Disabled write: reg_write=0, write_reg=5'h04, write_data=32'hDEAD_BEEF, edge -> register 4 keeps prior value.
REQ-031 Same-cycle read of write target: write 32'hA5A5_A5A5 to reg 7 with read_reg1=read_reg2=7 -> before edge old value (bypass off) or 32'hA5A5_A5A5 (REG_BANK_BYPASS_EN); after edge 32'hA5A5_A5A5 in both builds.
REQ-032 Sweep: write index i value i*32'h0101_0101 for i=1..31, then read all pairs -> each matches; index 0 reads 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the reg_bank register file.
// Optional forwarding is enabled with the REG_BANK_BYPASS_EN macro.
package reg_bank_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;
    localparam int ZERO_REG     = 0;

    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/reg_bank_rdport.sv
// One combinational read port: index decode, zero-register masking and,
// when REG_BANK_BYPASS_EN is defined, write-to-read forwarding.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              rst_n,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg,
    output logic [DATA_W-1:0] read_data
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

`ifdef REG_BANK_BYPASS_EN
    always_comb begin
        read_data = regs[read_reg];
        if (reg_write && write_reg != ZERO_IDX && read_reg == write_reg)
            read_data = write_data;
        if (read_reg == ZERO_IDX)
            read_data = '0;
        // Reset wins over forwarding so the port reads zero while rst_n is low.
        if (!rst_n)
            read_data = '0;
    end
`else
    // Write-side inputs only matter for forwarding; storage is already cleared by reset.
    logic unused_ok;
    assign unused_ok = ^{rst_n, reg_write, write_reg, write_data};

    always_comb begin
        read_data = regs[read_reg];
        if (read_reg == ZERO_IDX)
            read_data = '0;
    end
`endif

endmodule

// File: rtl/reg_bank.sv
// Two-read, one-write register file with register 0 hard-wired to zero.
// Define REG_BANK_BYPASS_EN to forward write_data to matching read ports.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Entry 0 is only ever cleared; the read ports also mask it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (reg_write && write_reg != ZERO_IDX) begin
            regs[write_reg] <= write_data;
        end
    end

    reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport1 (
        .rst_n      (rst_n),
        .regs       (regs),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg   (read_reg1),
        .read_data  (read_data1)
    );

    reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport2 (
        .rst_n      (rst_n),
        .regs       (regs),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg   (read_reg2),
        .read_data  (read_data2)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (default or REG_BANK_BYPASS_EN build).
module tb_reg_bank;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    reg_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic write_op(input logic we, input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        reg_write  = we;
        write_reg  = addr;
        write_data = data;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        read_reg1 = a1;
        read_reg2 = a2;
        #1;
    endtask

    function automatic logic [31:0] sweep_val(input int idx);
        logic [31:0] step;
        step = 32'h0101_0101;
        return (idx == 0) ? 32'h0 : step * 32'(idx);
    endfunction

    initial begin
        rst_n      = 1'b0;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        // reset state
        #12;
        rd(5'd5, 5'd0);
        check("reset_rd1", read_data1, 32'h0);
        check("reset_rd2", read_data2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic write / read
        write_op(1'b1, 5'h0D, 32'h1234_5678);
        rd(5'h0D, 5'h04);
        check("wr_rd_0d", read_data1, 32'h1234_5678);
        check("wr_rd_04", read_data2, 32'h0);

        // zero register discards writes
        write_op(1'b1, 5'h00, 32'hFFFF_FFFF);
        rd(5'h00, 5'h00);
        check("zero_rd1", read_data1, 32'h0);
        check("zero_rd2", read_data2, 32'h0);

        // disabled write leaves register 4 alone
        write_op(1'b1, 5'h04, 32'h1111_2222);
        write_op(1'b0, 5'h04, 32'hDEAD_BEEF);
        rd(5'h04, 5'h0D);
        check("nowr_04", read_data1, 32'h1111_2222);
        check("nowr_0d", read_data2, 32'h1234_5678);

        // same-cycle read of the write target
        write_op(1'b1, 5'h07, 32'h0000_0077);
        @(negedge clk);
        reg_write  = 1'b1;
        write_reg  = 5'h07;
        write_data = 32'hA5A5_A5A5;
        rd(5'h07, 5'h07);
`ifdef REG_BANK_BYPASS_EN
        check("same_pre_rd1", read_data1, 32'hA5A5_A5A5);
        check("same_pre_rd2", read_data2, 32'hA5A5_A5A5);
`else
        check("same_pre_rd1", read_data1, 32'h0000_0077);
        check("same_pre_rd2", read_data2, 32'h0000_0077);
`endif
        @(posedge clk);
        #1;
        check("same_post_rd1", read_data1, 32'hA5A5_A5A5);
        check("same_post_rd2", read_data2, 32'hA5A5_A5A5);
        // write to index 0 must never forward
        write_reg  = 5'h00;
        write_data = 32'h5555_AAAA;
        rd(5'h00, 5'h00);
        check("zero_fwd_rd1", read_data1, 32'h0);
        check("zero_fwd_rd2", read_data2, 32'h0);
        reg_write = 1'b0;

        // sweep every index, then read all pairs through the scoreboard
        for (int i = 1; i < 32; i++)
            write_op(1'b1, 5'(i), sweep_val(i));
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(sweep_val(i));
            exp_q.push_back(sweep_val(31 - i));
            rd(5'(i), 5'(31 - i));
            check($sformatf("sweep_p1_%0d", i), read_data1, exp_q.pop_front());
            check($sformatf("sweep_p2_%0d", i), read_data2, exp_q.pop_front());
        end

        // mid-run reset, asynchronous to the clock, with a write pending across an edge
        @(negedge clk);
        #2;
        rst_n      = 1'b0;
        reg_write  = 1'b1;
        write_reg  = 5'h05;
        write_data = 32'hCAFE_F00D;
        rd(5'h05, 5'h1F);
        check("arst_rd1", read_data1, 32'h0);
        check("arst_rd2", read_data2, 32'h0);
        @(posedge clk);
        #1;
        check("arst_edge_rd1", read_data1, 32'h0);
        @(negedge clk);
        reg_write = 1'b0;
        rst_n     = 1'b1;
        rd(5'h05, 5'h0D);
        check("rel_rd1", read_data1, 32'h0);
        check("rel_rd2", read_data2, 32'h0);

        // first edge after release takes the write
        write_op(1'b1, 5'h05, 32'hCAFE_F00D);
        rd(5'h05, 5'h06);
        check("post_rel_05", read_data1, 32'hCAFE_F00D);
        check("post_rel_06", read_data2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
